// File: rtl/i2s_rx_if.sv
//------------------------------------------------------------------------------
// Module      : i2s_rx_if
// Description : Bundle of the external I2S lines and the received sample pair
//               presented to the system side of the I2S receiver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface i2s_rx_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    i2s_bclk;
    logic                    i2s_lrck;
    logic                    i2s_sdata;
    logic [SAMPLE_WIDTH-1:0] left_sample;
    logic [SAMPLE_WIDTH-1:0] right_sample;
    logic                    sample_valid;
    logic                    frame_error;

    // Drives the serial lines and observes the received pair
    modport master (
        output i2s_bclk, i2s_lrck, i2s_sdata,
        input  left_sample, right_sample, sample_valid, frame_error
    );

    // The receiver: consumes the serial lines and produces the pair
    modport slave (
        input  i2s_bclk, i2s_lrck, i2s_sdata,
        output left_sample, right_sample, sample_valid, frame_error
    );
endinterface

`default_nettype wire

// File: rtl/i2s_rx.sv
//------------------------------------------------------------------------------
// Module      : i2s_rx
// Description : I2S (Philips format) slave receiver. Oversamples BCLK, LRCK and
//               SDATA in the clk domain, deserialises MSB-first words and emits
//               left/right pairs with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2s_rx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic clk,
    input  wire logic reset_n,
    i2s_rx_if.slave   bus
);

    localparam int               CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // A completed word is short when bit_cnt+1 < SAMPLE_WIDTH
    localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(SAMPLE_WIDTH - 1);

    // Synchroniser chains; index SYNC_STAGES-1 is the synchronised output
    logic [SYNC_STAGES-1:0]  bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0]  lrck_sync_q, lrck_sync_d;
    logic [SYNC_STAGES-1:0]  sdata_sync_q, sdata_sync_d;
    logic                    bclk_dly_q, bclk_dly_d;

    // Deserialiser state
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] word_q, word_d;
    logic                    ws_dly_q, ws_dly_d;
    logic                    synced_q, synced_d;
    logic                    left_seen_q, left_seen_d;
    logic [SAMPLE_WIDTH-1:0] left_pending_q, left_pending_d;
    logic                    short_l_q, short_l_d;

    // Output registers
    logic [SAMPLE_WIDTH-1:0] left_sample_q, left_sample_d;
    logic [SAMPLE_WIDTH-1:0] right_sample_q, right_sample_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    frame_error_q, frame_error_d;

    logic                    bclk_s;
    logic                    ws;
    logic                    sd;
    logic                    bclk_rise;
    logic [SAMPLE_WIDTH-1:0] word_w;
    logic                    short_w;

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign ws        = lrck_sync_q[SYNC_STAGES-1];
    assign sd        = sdata_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_dly_q;

    // Shift the raw pins into the synchronisers; bclk gets one extra delay flop
    always_comb begin
        bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], bus.i2s_bclk};
        lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], bus.i2s_lrck};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], bus.i2s_sdata};
        bclk_dly_d   = bclk_s;
    end

    // Current word with this edge's bit inserted, and its short-word flag
    always_comb begin
        word_w = word_q;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            // Position MSB-first; counts past SAMPLE_WIDTH match no bit, so
            // long slots are truncated to their MSBs
            if (bit_cnt_q == CNT_W'(SAMPLE_WIDTH - 1 - i)) begin
                word_w[i] = sd;
            end
        end
        short_w = (bit_cnt_q < SHORT_LIM);
    end

    // Per-BCLK-edge deserialiser: accumulate bits, close words on an LRCK change
    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        word_d         = word_q;
        ws_dly_d       = ws_dly_q;
        synced_d       = synced_q;
        left_seen_d    = left_seen_q;
        left_pending_d = left_pending_q;
        short_l_d      = short_l_q;
        left_sample_d  = left_sample_q;
        right_sample_d = right_sample_q;
        sample_valid_d = 1'b0;
        frame_error_d  = frame_error_q;

        if (bclk_rise) begin
            if (ws == ws_dly_q) begin
                word_d    = word_w;
                bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
            end else begin
                // One-BCLK delay: this bit is the LSB of the word just ending
                if (!ws_dly_q) begin
                    if (synced_q) begin
                        left_pending_d = word_w;
                        short_l_d      = short_w;
                        left_seen_d    = 1'b1;
                    end
                end else begin
                    if (synced_q && left_seen_q) begin
                        left_sample_d  = left_pending_q;
                        right_sample_d = word_w;
                        sample_valid_d = 1'b1;
                        frame_error_d  = short_l_q | short_w;
                        left_seen_d    = 1'b0;
                    end
                    // A right->left change marks a frame start we can trust
                    synced_d = 1'b1;
                end
                bit_cnt_d = '0;
                word_d    = '0;
                ws_dly_d  = ws;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_q    <= '0;
            lrck_sync_q    <= '0;
            sdata_sync_q   <= '0;
            bclk_dly_q     <= 1'b0;
            bit_cnt_q      <= '0;
            word_q         <= '0;
            ws_dly_q       <= 1'b0;
            synced_q       <= 1'b0;
            left_seen_q    <= 1'b0;
            left_pending_q <= '0;
            short_l_q      <= 1'b0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            bclk_sync_q    <= bclk_sync_d;
            lrck_sync_q    <= lrck_sync_d;
            sdata_sync_q   <= sdata_sync_d;
            bclk_dly_q     <= bclk_dly_d;
            bit_cnt_q      <= bit_cnt_d;
            word_q         <= word_d;
            ws_dly_q       <= ws_dly_d;
            synced_q       <= synced_d;
            left_seen_q    <= left_seen_d;
            left_pending_q <= left_pending_d;
            short_l_q      <= short_l_d;
            left_sample_q  <= left_sample_d;
            right_sample_q <= right_sample_d;
            sample_valid_q <= sample_valid_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign bus.left_sample  = left_sample_q;
    assign bus.right_sample = right_sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.frame_error  = frame_error_q;

endmodule

`default_nettype wire

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S slave receiver: the capture-side counterpart of the existing I2S transmitter.
- Oversamples external BCLK/LRCK/SDATA in the system clock domain and deserialises standard Philips-format I2S.
- Presents left/right sample pairs to the system with a single-cycle valid strobe.
- Sits beside the audio path, with outputs feeding CPU-visible registers or a sample FIFO.

Parameters:
- SAMPLE_WIDTH, 16, bits kept per channel word (MSB-justified); legal range 8..32.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers; minimum 2.

Ports:
- clk  input  1  system clock; must be at least 4x the BCLK frequency.
- reset_n  input  1  asynchronous, active-low reset.
- i2s_bclk  input  1  external bit clock, asynchronous to clk.
- i2s_lrck  input  1  word select; 0 = left, 1 = right.
- i2s_sdata  input  1  serial data, MSB first.
- left_sample  output  SAMPLE_WIDTH  last completed left word.
- right_sample  output  SAMPLE_WIDTH  last completed right word.
- sample_valid  output  1  one-clk pulse; the pair was updated this cycle.
- frame_error  output  1  qualifies the current pair; 1 = either word had fewer than SAMPLE_WIDTH bits.

Behaviour:
- Interface: clk and reset_n only; reset is asynchronous, active-low.
- Reset values: all outputs 0. Internal state cleared: bit_cnt=0, word=0, synced=0, ws_d=0, left_pending=0, all sync flops 0.
- Synchronisation: bclk, lrck and sdata each pass through SYNC_STAGES flops. bclk gets one extra flop for edge detection.
- BCLK rising edge detected when the synced bclk is 1 and its delayed copy is 0. All shift and capture actions occur only on that clk cycle.
- Latency: registered outputs change SYNC_STAGES+1 clk edges after the first clk edge that samples i2s_bclk high.
- On each detected rising edge, sample ws (synced lrck) and sd (synced sdata), then:
  - ws == ws_d (mid-word):
    - if bit_cnt < SAMPLE_WIDTH: word[SAMPLE_WIDTH-1-bit_cnt] <= sd.
    - bit_cnt increments, saturating at 63 (6-bit counter).
    - Bits beyond SAMPLE_WIDTH are ignored, so 24/32-bit slots truncate to the MSBs.
  - ws != ws_d (word boundary; this bit is the last bit of the ws_d word, per the one-BCLK I2S delay):
    - Store sd into the current word by the mid-word rule, producing the completed word w with n = bit_cnt+1 bits.
    - ws_d = 0 and synced: left_pending <= w; short_l <= (n < SAMPLE_WIDTH).
    - ws_d = 1 and synced and left_seen: left_sample <= left_pending; right_sample <= w; sample_valid <= 1; frame_error <= short_l | (n < SAMPLE_WIDTH); left_seen <= 0.
    - A 1->0 transition sets synced. Every ws_d = 0 completion sets left_seen while synced.
    - Always: bit_cnt <= 0, word <= 0, ws_d <= ws.
- Short words are left-justified with zero LSBs (bits never written stay 0).
- Startup: every word completed before the first 1->0 lrck transition is discarded, so the first pair out is always a full left+right pair.
- A right completion without a preceding synced left produces no strobe.
- sample_valid is high for exactly one clk per pair, otherwise 0. left_sample, right_sample and frame_error hold between strobes.
- A reset_n assertion mid-word immediately returns everything to reset values. A partial frame in progress is lost, and the resync rule above applies again.
- A bclk glitch shorter than one clk period is not guaranteed to be captured; the clk >= 4x bclk ratio is a usage constraint and is not checked.

Test Plan:
- 16-bit slots, SAMPLE_WIDTH=16, L=0xA5C3 / R=0x1234 repeated, clk = 8x bclk -> after the startup discard, sample_valid pulses once per frame with left=0xA5C3, right=0x1234, frame_error=0.
- 32-bit slots carrying L=0x8001FFFF / R=0x7FFE0000 -> left=0x8001, right=0x7FFE; extra bits ignored; one pulse per 64 BCLKs.
- Stream started mid right word, lrck initially 1 -> no pulse until a full left then right completes; the first pulse carries correct data.
- Left word of only 12 bits (0xABC), right 16 bits 0x5555 -> left=0xABC0, right=0x5555, frame_error=1; next normal frame -> frame_error=0.
- reset_n pulsed low mid right word -> outputs 0 immediately; after release, no pulse until the next synced left+right pair; the data is correct.
- clk = 4x bclk, randomized phase between bclk and clk -> no lost or duplicated bits over 1000 frames; data matches the scoreboard.
